// File: rtl/uart_trx_if.sv
// Bus-side handshake bundle of uart_trx: TX payload valid/ready plus the RX result
// registers. master = register block, slave = UART core.
interface uart_trx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic              tx_done_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              rx_parity_err_o;
  logic              rx_frame_err_o;

  modport master (
    output tx_data_i, tx_valid_i,
    input  tx_ready_o, tx_done_o, rx_data_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o
  );

  modport slave (
    input  tx_data_i, tx_valid_i,
    output tx_ready_o, tx_done_o, rx_data_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o
  );
endinterface

// File: rtl/uart_trx.sv
// Full-duplex UART: shared x16 baud tick, TX frame FSM with valid/ready accept,
// RX frame FSM with 2-flop synchroniser, mid-bit sampling and parity/framing flags.
module uart_trx #(
  parameter int BAUDRATE_CNT_WIDTH = 16,
  parameter int DATA_W             = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_en_i,
  input  logic                          tx_en_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          stop2_i,
  input  logic [BAUDRATE_CNT_WIDTH-1:0] bauds_lim_i,
  input  logic                          rx_i,
  output logic                          tx_o,
  uart_trx_if.slave                     bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  // ---------------------------------------------------------------- baud tick
  logic [BAUDRATE_CNT_WIDTH-1:0] baud_cnt;
  logic                          baud_run;
  logic                          tick;

  assign baud_run = tx_en_i || rx_en_i;
  assign tick     = baud_run && (baud_cnt == bauds_lim_i);

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i)         baud_cnt <= '0;
    else if (tick)     baud_cnt <= '0;
    else if (baud_run) baud_cnt <= baud_cnt + 1'b1;
  end

  // ---------------------------------------------------------------- transmitter
  state_e            tx_state, tx_next;
  logic [3:0]        tx_tick_cnt;
  logic [3:0]        tx_bit_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_par_bit;
  logic              tx_par_en;
  logic              tx_stop2;
  logic              tx_done_q;
  logic              tx_accept;
  logic              tx_bit_end;
  logic              tx_exit;

  // Reset gates ready combinationally so no accept can slip in while rst_i is high.
  assign bus.tx_ready_o = (tx_state == S_IDLE) && tx_en_i && !rst_i;
  assign bus.tx_done_o  = tx_done_q;
  assign tx_accept      = bus.tx_valid_i && bus.tx_ready_o;
  assign tx_bit_end     = tick && (tx_tick_cnt == 4'd15);

  always_ff @(posedge clk_i) begin
    if (rst_i) tx_state <= S_IDLE;
    else       tx_state <= tx_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    tx_next = tx_state;
    tx_exit = 1'b0;
    tx_o    = 1'b1;
    unique case (tx_state)
      S_IDLE:   if (tx_accept) tx_next = S_START;
      S_START: begin
        tx_o = 1'b0;
        if (tx_bit_end) tx_next = S_DATA;
      end
      S_DATA: begin
        tx_o = tx_shift[0];
        if (tx_bit_end && (tx_bit_cnt == LAST_BIT))
          tx_next = tx_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx_o = tx_par_bit;
        if (tx_bit_end) tx_next = S_STOP;
      end
      S_STOP: begin
        if (tx_bit_end && (!tx_stop2 || (tx_bit_cnt == 4'd1))) begin
          tx_next = S_IDLE;
          tx_exit = 1'b1;
        end
      end
      default: tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_tick_cnt <= '0;
      tx_bit_cnt  <= '0;
      tx_shift    <= '0;
      tx_par_bit  <= 1'b0;
      tx_par_en   <= 1'b0;
      tx_stop2    <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_done_q <= tx_exit;
      if (tx_accept) begin
        tx_shift   <= bus.tx_data_i;
        tx_par_bit <= (^bus.tx_data_i) ^ parity_odd_i;
        tx_par_en  <= parity_en_i;
        tx_stop2   <= stop2_i;
      end
      // Counters restart on every state entry; within a state the tick counter
      // wraps every 16 ticks and the bit counter tracks data / stop bits.
      if (tx_next != tx_state) begin
        tx_tick_cnt <= '0;
        tx_bit_cnt  <= '0;
      end else if (tick) begin
        tx_tick_cnt <= tx_tick_cnt + 1'b1;
        if (tx_tick_cnt == 4'd15) begin
          tx_bit_cnt <= tx_bit_cnt + 1'b1;
          if (tx_state == S_DATA) tx_shift <= tx_shift >> 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- receiver
  logic [1:0]        rx_sync;
  logic              rx_s;
  state_e            rx_state, rx_next;
  logic [3:0]        rx_tick_cnt;
  logic [3:0]        rx_bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_perr_pend;
  logic              rx_mid;
  logic              rx_commit;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              rx_perr_q;
  logic              rx_ferr_q;

  assign rx_s                = rx_sync[1];
  // START ends at its own mid-bit, so later bits are sampled 16 ticks apart.
  assign rx_mid              = tick && (rx_tick_cnt == 4'd15);
  assign bus.rx_data_o       = rx_data_q;
  assign bus.rx_valid_o      = rx_valid_q;
  assign bus.rx_parity_err_o = rx_perr_q;
  assign bus.rx_frame_err_o  = rx_ferr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_sync  <= 2'b11;
      rx_state <= S_IDLE;
    end else begin
      rx_sync  <= {rx_sync[0], rx_i};
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next   = rx_state;
    rx_commit = 1'b0;
    unique case (rx_state)
      S_IDLE:   if (tick && !rx_s) rx_next = S_START;
      S_START:  if (tick && (rx_tick_cnt == 4'd7)) rx_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (rx_mid && (rx_bit_cnt == LAST_BIT))
                  rx_next = parity_en_i ? S_PARITY : S_STOP;
      S_PARITY: if (rx_mid) rx_next = S_STOP;
      S_STOP: begin
        if (rx_mid) begin
          rx_next   = S_IDLE;
          rx_commit = 1'b1;
        end
      end
      default:  rx_next = S_IDLE;
    endcase
    if (!rx_en_i) begin
      rx_next   = S_IDLE;
      rx_commit = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_tick_cnt  <= '0;
      rx_bit_cnt   <= '0;
      rx_shift     <= '0;
      rx_perr_pend <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
    end else begin
      rx_valid_q <= rx_commit;
      if (rx_next != rx_state) begin
        rx_tick_cnt <= '0;
        rx_bit_cnt  <= '0;
      end else if (tick) begin
        rx_tick_cnt <= rx_tick_cnt + 1'b1;
        if (rx_tick_cnt == 4'd15) rx_bit_cnt <= rx_bit_cnt + 1'b1;
      end
      if ((rx_state == S_DATA) && rx_mid) rx_shift <= {rx_s, rx_shift[DATA_W-1:1]};
      if (rx_state == S_IDLE) rx_perr_pend <= 1'b0;
      else if ((rx_state == S_PARITY) && rx_mid)
        rx_perr_pend <= rx_s ^ (^rx_shift) ^ parity_odd_i;
      if (rx_commit) begin
        rx_data_q <= rx_shift;
        rx_perr_q <= rx_perr_pend;
        rx_ferr_q <= !rx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_trx.sv
// Directed bench for uart_trx: stimulus pushes expected TX line frames and RX results
// into queues; independent monitors on tx_o and rx_valid_o pop and compare.
module tb_uart_trx;
  localparam int DW      = 8;
  localparam int BW      = 16;
  localparam int BIT_CLK = 64;  // bauds_lim_i=3 -> 4 clk per tick, 16 ticks per bit

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_en, tx_en, par_en, par_odd, stop2;
  logic [BW-1:0] lim;
  logic          rx_drv, loop, rx_line, tx_line;
  int            cyc = 0;

  uart_trx_if #(.DATA_W(DW)) bus ();

  assign rx_line = loop ? tx_line : rx_drv;

  uart_trx #(.BAUDRATE_CNT_WIDTH(BW), .DATA_W(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_en_i      (rx_en),
    .tx_en_i      (tx_en),
    .parity_en_i  (par_en),
    .parity_odd_i (par_odd),
    .stop2_i      (stop2),
    .bauds_lim_i  (lim),
    .rx_i         (rx_line),
    .tx_o         (tx_line),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  typedef struct {
    logic [11:0] bits;  // bit i = i-th bit on the line, start bit first
    int          n;
  } tx_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
  } rx_exp_t;

  tx_exp_t tx_q[$];
  rx_exp_t rx_q[$];
  bit      tx_mon_en = 1'b1;
  bit      tx_busy   = 1'b0;
  int      rx_vcount = 0;

  // TX monitor: frame starts at a falling edge; sample each bit at its middle.
  initial begin : tx_mon
    logic        prev;
    tx_exp_t     e;
    logic [11:0] got;
    int          t0;
    bit          seen;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mon_en && !rst && prev && !tx_line) begin
        tx_busy = 1'b1;
        t0      = cyc;
        got     = '0;
        if (tx_q.size() == 0) begin
          check("tx_unexpected_frame", 32'd1, 32'd0);
          e.bits = '0;
          e.n    = 10;
        end else begin
          e = tx_q.pop_front();
        end
        repeat (BIT_CLK / 2) @(negedge clk);
        for (int i = 0; i < e.n; i++) begin
          if (i > 0) repeat (BIT_CLK) @(negedge clk);
          got[i] = tx_line;
        end
        check("tx_frame_bits", 32'(got), 32'(e.bits));
        seen = 1'b0;
        for (int k = 0; k < 2 * BIT_CLK && !seen; k++) begin
          if (bus.tx_done_o) seen = 1'b1;
          else @(negedge clk);
        end
        if (seen) check_range("tx_done_latency", cyc - t0, e.n * BIT_CLK - 4, e.n * BIT_CLK + 1);
        else      check("tx_done_timeout", 32'd0, 32'd1);
        tx_busy = 1'b0;
      end
      prev = tx_line;
    end
  end

  // RX monitor: every valid pulse must match the oldest expected result.
  initial begin : rx_mon
    rx_exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rx_valid_o) begin
        rx_vcount++;
        if (rx_q.size() == 0) begin
          check("rx_unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = rx_q.pop_front();
          check("rx_data", 32'(bus.rx_data_o), 32'(e.data));
          check("rx_parity_err", 32'(bus.rx_parity_err_o), 32'(e.perr));
          check("rx_frame_err", 32'(bus.rx_frame_err_o), 32'(e.ferr));
        end
      end
    end
  end

  task automatic push_tx(input logic [11:0] bits, input int n);
    tx_exp_t e;
    e.bits = bits;
    e.n    = n;
    tx_q.push_back(e);
  endtask

  task automatic push_rx(input logic [DW-1:0] d, input logic perr, input logic ferr);
    rx_exp_t e;
    e.data = d;
    e.perr = perr;
    e.ferr = ferr;
    rx_q.push_back(e);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!bus.tx_ready_o && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (!bus.tx_ready_o) check("tx_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_tx(input logic [DW-1:0] d);
    wait_ready();
    bus.tx_data_i  = d;
    bus.tx_valid_i = 1'b1;
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((tx_q.size() != 0 || tx_busy || rx_q.size() != 0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) check("drain_timeout", 32'd0, 32'd1);
    repeat (20) @(negedge clk);
  endtask

  // Serial driver for the RX path; parity computed from the payload, optionally flipped.
  task automatic drive_rx(input logic [DW-1:0] d, input bit pen, input bit podd,
                          input bit pflip, input logic stop_bit);
    rx_drv = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      rx_drv = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    if (pen) begin
      rx_drv = (^d) ^ podd ^ pflip;
      repeat (BIT_CLK) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (BIT_CLK) @(negedge clk);
    rx_drv = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  initial begin
    int v0;
    int k;
    rst = 1'b1; tx_en = 1'b0; rx_en = 1'b0; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
    lim = 16'd3; loop = 1'b0; rx_drv = 1'b1;
    bus.tx_valid_i = 1'b0;
    bus.tx_data_i  = '0;
    repeat (3) @(negedge clk);

    check("rst_tx_o", 32'(tx_line), 32'd1);
    check("rst_tx_ready", 32'(bus.tx_ready_o), 32'd0);
    check("rst_tx_done", 32'(bus.tx_done_o), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid_o), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data_o), 32'd0);
    check("rst_rx_perr", 32'(bus.rx_parity_err_o), 32'd0);
    check("rst_rx_ferr", 32'(bus.rx_frame_err_o), 32'd0);

    rst = 1'b0; tx_en = 1'b1; rx_en = 1'b1;
    repeat (5) @(negedge clk);

    // Vector 1: 0xA5, no parity, 1 stop -> 0,1,0,1,0,0,1,0,1,1
    push_tx(12'b00_1101001010, 10);
    send_tx(8'hA5);
    drain();

    // Vector 2: loopback, odd parity, 0x3C -> parity bit 1
    loop = 1'b1; par_en = 1'b1; par_odd = 1'b1;
    push_tx(12'b0_11001111000, 11);
    push_rx(8'h3C, 1'b0, 1'b0);
    send_tx(8'h3C);
    drain();
    loop = 1'b0; par_en = 1'b0; par_odd = 1'b0;
    repeat (10) @(negedge clk);

    // Vector 3: 3-tick glitch is rejected, then a clean frame is received
    v0 = rx_vcount;
    rx_drv = 1'b0;
    repeat (12) @(negedge clk);
    rx_drv = 1'b1;
    repeat (6 * BIT_CLK) @(negedge clk);
    check("glitch_no_valid", 32'(rx_vcount), 32'(v0));
    push_rx(8'hC3, 1'b0, 1'b0);
    drive_rx(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // Vector 4: stop bit low on 0x55 -> data delivered with frame error
    push_rx(8'h55, 1'b0, 1'b1);
    drive_rx(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Vector 5: even parity, flipped parity bit on 0x0F, then a clean frame clears it
    par_en = 1'b1; par_odd = 1'b0;
    push_rx(8'h0F, 1'b1, 1'b0);
    drive_rx(8'h0F, 1'b1, 1'b0, 1'b1, 1'b1);
    push_rx(8'h0F, 1'b0, 1'b0);
    drive_rx(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();
    par_en = 1'b0;

    // Vector 6a: reset in the middle of the data bits of 0x00
    tx_mon_en = 1'b0;
    send_tx(8'h00);
    repeat (3 * BIT_CLK) @(negedge clk);
    check("mid_data_tx_low", 32'(tx_line), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_o", 32'(tx_line), 32'd1);
    check("mid_rst_tx_ready", 32'(bus.tx_ready_o), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_tx_ready", 32'(bus.tx_ready_o), 32'd1);
    tx_mon_en = 1'b1;

    // Vector 6b: valid held high, stop2 -> two back-to-back 11-bit frames
    stop2 = 1'b1;
    push_tx(12'b0_11100000010, 11);
    push_tx(12'b0_11011111100, 11);
    wait_ready();
    bus.tx_data_i  = 8'h81;
    bus.tx_valid_i = 1'b1;
    @(negedge clk);
    bus.tx_data_i = 8'h7E;
    k = 0;
    while (!bus.tx_ready_o && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!bus.tx_ready_o) check("b2b_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
    drain();
    stop2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
